pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register: the successor to the fixed-field inter-stage registers between EX and MEM. It carries an opaque WIDTH-bit payload with a valid/ready handshake. The existing pipeline control word (`CTRL_STATE_Default` / `CTRL_STATE_Bubble` / `CTRL_STATE_Stalled` from defines.v) is honoured, and stall/bubble activity is counted. Instances sit between any two pipeline stages; the payload packs rd address, write enable, write data and whatever else a stage forwards.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (≥1).
- BUBBLE_VAL, {WIDTH{1'b0}}, payload value loaded on bubble/flush and reset.
- CNT_W, 16, width of each activity counter (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ctrl_signal_i  in  `CTRL_Wire_Bus  stage control word.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept payload.
- in_data_i  in  WIDTH  upstream payload.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts payload.
- out_data_o  out  WIDTH  downstream payload, driven directly from the main register.
- occ_o  out  2  entries held (0..2; max 1 without skid).
- stall_cnt_o  out  CNT_W  cycles spent in Stalled, saturating.
- bubble_cnt_o  out  CNT_W  cycles spent in Bubble, saturating.

## Operation
- Storage: main register M (valid bit Mv, data Md). Skid register S (Sv, Sd) exists only when skid is compiled in.
- Control decode:
  - Default: normal handshake.
  - Stalled: all state frozen; in_ready_o=0; out_valid_o masked to 0. No transfer on either side.
  - Bubble, or any other encoding: flush.
- Flush (Bubble):
  - On the next edge Mv=0, Sv=0, Md=BUBBLE_VAL.
  - in_ready_o=0 and out_valid_o=0 during the Bubble cycle.
  - Held entries are discarded, never delivered.
- Transfers happen only in Default:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - out_valid_o = Mv & Default.
- Skid compiled in:
  - in_ready_o = ~Sv & Default (Sv is registered, so in_ready_o has no combinational path from out_ready_i).
  - When M is empty or out_fire: M loads from S if Sv, else from input if in_fire, else Mv=0.
  - If in_fire while M keeps its entry, or while M is reloaded from S, the input goes to S.
  - Otherwise, after out_fire with Sv set, Sv clears.
  - Order is strictly FIFO: S is never overtaken by the input.
- Counters:
  - stall_cnt_o increments on every Stalled cycle; bubble_cnt_o on every Bubble or illegal-encoding cycle.
  - Both saturate at all-ones, with no wrap.
  - Counters are cleared only by reset.
- occ_o = Mv + Sv.

## Timing
- Reset values (asynchronous, while rst=0): Mv=0, Sv=0, Md=Sd=BUBBLE_VAL, counters 0, out_valid_o=0, occ_o=0.
- After reset release with ctrl=Default: in_ready_o=1.
- Latency: payload accepted at edge N appears on out_data_o with out_valid_o=1 after edge N.
- Throughput: 1 transfer/cycle while out_ready_i=1.
- Skid absorbs exactly one beat after out_ready_i falls. in_ready_o drops the cycle after S fills.
- Simultaneous in_fire and out_fire with only M full: M takes the new beat and occ stays 1.
- Stalled→Default: the held entry reappears unchanged on out_valid_o in the first Default cycle.
- Bubble takes priority over any concurrent in_valid_i/out_ready_i. The post-flush state is identical to reset, except the counters are kept.
- Reset asserted mid-transfer: both entries lost immediately; outputs go to reset values without waiting for clk.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer as above; in_ready_o registered-only path.
- PIPE_STAGE_SKID_EN undefined:
  - S is absent and occ_o ≤ 1.
  - in_ready_o = (~Mv | out_ready_i) & Default, a combinational path from out_ready_i.
  - M loads on in_fire; Mv clears on out_fire without in_fire.
  - Full throughput is still 1/cycle.

## Test plan
- Reset: rst=0 with in_valid_i=1 → out_valid_o=0, out_data_o=BUBBLE_VAL, occ_o=0, counters 0; after release in_ready_o=1.
- Streaming: Default, out_ready_i=1, payloads 0x1..0x8 back-to-back → 0x1..0x8 out in order, one cycle later each, no gaps.
- Backpressure (skid on):
  - Send 0xA, 0xB; drop out_ready_i after 0xA is registered → occ_o=2 and in_ready_o=0.
  - Raise out_ready_i → 0xA then 0xB delivered, no loss or duplication.
- Stall: hold entry 0x55, Stalled for 3 cycles → out_valid_o=0, in_ready_o=0, stall_cnt_o=3; back to Default → 0x55 delivered.
- Flush: occ_o=2, one Bubble cycle with in_valid_i=1 → occ_o=0, out_data_o=BUBBLE_VAL, bubble_cnt_o=1, input not consumed.
- Saturation: CNT_W=2, 5 Stalled cycles → stall_cnt_o=3, held.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready
// handshake, honouring the pipeline control word (Default/Bubble/Stalled).
// It also counts the cycles spent in Stalled and in Bubble.
//
// Optional feature: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
// in_ready_o then depends only on registered state. Without it the stage
// holds one entry, and in_ready_o depends combinationally on out_ready_i.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   ctrl_signal_i                 stage control word
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
//   occ_o                         entries held (0..2)
//   stall_cnt_o, bubble_cnt_o     saturating activity counters

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus [1:0]
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b01
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'b10
`endif

module pipe_stage_reg #(
   parameter int unsigned      WIDTH      = 64,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic `CTRL_Wire_Bus ctrl_signal_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [WIDTH-1:0]    in_data_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [WIDTH-1:0]    out_data_o,
   output logic [1:0]          occ_o,
   output logic [CNT_W-1:0]    stall_cnt_o,
   output logic [CNT_W-1:0]    bubble_cnt_o
);

   logic             is_default;
   logic             is_stall;
   logic             is_flush;
   logic             in_fire;
   logic             out_fire;

   logic             mv_q, mv_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Control decode: anything that is neither Default nor Stalled flushes.
   assign is_default = (ctrl_signal_i == `CTRL_STATE_Default);
   assign is_stall   = (ctrl_signal_i == `CTRL_STATE_Stalled);
   assign is_flush   = ~is_default & ~is_stall;

   assign out_valid_o  = mv_q & is_default;
   assign out_data_o   = md_q;
   assign in_fire      = in_valid_i & in_ready_o;
   assign out_fire     = out_valid_o & out_ready_i;
   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
   logic             sv_q, sv_d;
   logic [WIDTH-1:0] sd_q, sd_d;

   // Ready depends only on the registered skid flag.
   assign in_ready_o = ~sv_q & is_default;
   assign occ_o      = {1'b0, mv_q} + {1'b0, sv_q};

   // Next state: M refills from S first, so order stays FIFO.
   always_comb begin
      mv_d = mv_q;
      md_d = md_q;
      sv_d = sv_q;
      sd_d = sd_q;
      if (is_flush) begin
         mv_d = 1'b0;
         md_d = BUBBLE_VAL;
         sv_d = 1'b0;
         sd_d = BUBBLE_VAL;
      end else if (is_default) begin
         if (~mv_q | out_fire) begin
            if (sv_q) begin
               mv_d = 1'b1;
               md_d = sd_q;
               sv_d = in_fire;
               if (in_fire) begin
                  sd_d = in_data_i;
               end
            end else if (in_fire) begin
               mv_d = 1'b1;
               md_d = in_data_i;
            end else begin
               mv_d = 1'b0;
            end
         end else if (in_fire) begin
            sv_d = 1'b1;
            sd_d = in_data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sv_q <= 1'b0;
         sd_q <= BUBBLE_VAL;
      end else begin
         sv_q <= sv_d;
         sd_q <= sd_d;
      end
   end
`else
   // Single entry: accept whenever M is empty or being drained this cycle.
   assign in_ready_o = (~mv_q | out_ready_i) & is_default;
   assign occ_o      = {1'b0, mv_q};

   always_comb begin
      mv_d = mv_q;
      md_d = md_q;
      if (is_flush) begin
         mv_d = 1'b0;
         md_d = BUBBLE_VAL;
      end else if (in_fire) begin
         mv_d = 1'b1;
         md_d = in_data_i;
      end else if (out_fire) begin
         mv_d = 1'b0;
      end
   end
`endif

   // Saturating activity counters, cleared only by reset.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (is_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (is_flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mv_q         <= 1'b0;
         md_q         <= BUBBLE_VAL;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         mv_q         <= mv_d;
         md_q         <= md_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (WIDTH=8, BUBBLE_VAL=8'hE5),
// plus a second instance with CNT_W=2 for counter saturation.

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus [1:0]
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b01
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'b10
`endif

module tb_pipe_stage_reg;

   localparam logic [7:0] BV = 8'hE5;

   logic                clk = 1'b0;
   logic                rst;
   logic `CTRL_Wire_Bus ctrl;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_data;
   logic                out_valid;
   logic                out_ready;
   logic [7:0]          out_data;
   logic [1:0]          occ;
   logic [15:0]         stall_cnt;
   logic [15:0]         bubble_cnt;

   logic `CTRL_Wire_Bus s_ctrl;
   logic                s_in_ready;
   logic                s_out_valid;
   logic [7:0]          s_out_data;
   logic [1:0]          s_occ;
   logic [1:0]          s_stall_cnt;
   logic [1:0]          s_bubble_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(8), .BUBBLE_VAL(BV), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .occ_o(occ), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
   );

   pipe_stage_reg #(.WIDTH(8), .BUBBLE_VAL(BV), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .ctrl_signal_i(s_ctrl),
      .in_valid_i(1'b0), .in_ready_o(s_in_ready), .in_data_i(8'h00),
      .out_valid_o(s_out_valid), .out_ready_i(1'b0), .out_data_o(s_out_data),
      .occ_o(s_occ), .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; ctrl = `CTRL_STATE_Default; s_ctrl = `CTRL_STATE_Default;
      in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      total++; if (out_data !== BV) begin bad++; $display("FAIL rst_data got %h exp %h", out_data, BV); end
      total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ got %0d exp 0", occ); end
      total++; if ({stall_cnt, bubble_cnt} !== 32'd0) begin bad++; $display("FAIL rst_cnt got %h exp 0", {stall_cnt, bubble_cnt}); end
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b exp 1", in_ready); end
      tick();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin in_valid = 1'b1; in_data = 8'(i + 1); end
         else in_valid = 1'b0;
         @(negedge clk);
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
         if (i == 0) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first got %b exp 0", out_valid); end
         end else begin
            total++; if ({out_valid, out_data} !== {1'b1, 8'(i)}) begin bad++; $display("FAIL stream_out[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, 8'(i)); end
            total++; if (occ !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occ); end
         end
         tick();
      end
      @(negedge clk);
      total++; if ({out_valid, occ} !== 3'b000) begin bad++; $display("FAIL stream_drain got %b/%0d exp 0/0", out_valid, occ); end
      tick();
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b1;
      tick();
      in_data = 8'h0B; out_ready = 1'b0;
      @(negedge clk);
      total++; if ({out_valid, out_data} !== {1'b1, 8'h0A}) begin bad++; $display("FAIL bp_head got %b/%h exp 1/0a", out_valid, out_data); end
`ifdef PIPE_STAGE_SKID_EN
      tick();
      in_data = 8'h0C;
      @(negedge clk);
      total++; if (occ !== 2'd2) begin bad++; $display("FAIL bp_occ got %0d exp 2", occ); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got %b exp 0", in_ready); end
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
`else
      total++; if ({occ, in_ready} !== 3'b010) begin bad++; $display("FAIL bp_full got %0d/%b exp 1/0", occ, in_ready); end
      tick();
      out_ready = 1'b1;
`endif
      @(negedge clk);
      total++; if ({out_valid, out_data} !== {1'b1, 8'h0A}) begin bad++; $display("FAIL bp_first got %b/%h exp 1/0a", out_valid, out_data); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      total++; if ({out_valid, out_data} !== {1'b1, 8'h0B}) begin bad++; $display("FAIL bp_second got %b/%h exp 1/0b", out_valid, out_data); end
      total++; if (occ !== 2'd1) begin bad++; $display("FAIL bp_occ1 got %0d exp 1", occ); end
      tick();
      @(negedge clk);
      total++; if ({out_valid, occ} !== 3'b000) begin bad++; $display("FAIL bp_empty got %b/%0d exp 0/0", out_valid, occ); end
   endtask

   task automatic test_stall();
      in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
      tick();
      ctrl = `CTRL_STATE_Stalled; in_data = 8'h66; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if ({out_valid, in_ready} !== 2'b00) begin bad++; $display("FAIL stall_mask[%0d] got %b/%b exp 0/0", i, out_valid, in_ready); end
         tick();
      end
      ctrl = `CTRL_STATE_Default; in_valid = 1'b0;
      @(negedge clk);
      total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
      total++; if ({out_valid, out_data} !== {1'b1, 8'h55}) begin bad++; $display("FAIL stall_resume got %b/%h exp 1/55", out_valid, out_data); end
      tick();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
      tick();
`ifdef PIPE_STAGE_SKID_EN
      in_data = 8'h22;
      tick();
      @(negedge clk);
      total++; if (occ !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got %0d exp 2", occ); end
`else
      @(negedge clk);
      total++; if (occ !== 2'd1) begin bad++; $display("FAIL flush_pre_occ got %0d exp 1", occ); end
`endif
      tick();
      ctrl = `CTRL_STATE_Bubble; in_data = 8'h33; out_ready = 1'b1;
      @(negedge clk);
      total++; if ({out_valid, in_ready} !== 2'b00) begin bad++; $display("FAIL flush_mask got %b/%b exp 0/0", out_valid, in_ready); end
      tick();
      ctrl = `CTRL_STATE_Default; in_valid = 1'b0;
      @(negedge clk);
      total++; if ({out_valid, occ} !== 3'b000) begin bad++; $display("FAIL flush_empty got %b/%0d exp 0/0", out_valid, occ); end
      total++; if (out_data !== BV) begin bad++; $display("FAIL flush_data got %h exp %h", out_data, BV); end
      total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL flush_cnt got %0d exp 1", bubble_cnt); end
      tick();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_consume got %b exp 0", out_valid); end
      // Illegal encoding flushes like Bubble.
      in_valid = 1'b1; in_data = 8'h77;
      tick();
      ctrl = 2'b11; in_valid = 1'b0;
      tick();
      ctrl = `CTRL_STATE_Default;
      @(negedge clk);
      total++; if ({out_valid, occ, out_data} !== {1'b0, 2'd0, BV}) begin bad++; $display("FAIL illegal_flush got %b/%0d/%h exp 0/0/%h", out_valid, occ, out_data, BV); end
      total++; if ({stall_cnt, bubble_cnt} !== {16'd3, 16'd2}) begin bad++; $display("FAIL illegal_cnt got %0d/%0d exp 3/2", stall_cnt, bubble_cnt); end
      tick();
   endtask

   task automatic test_saturation();
      s_ctrl = `CTRL_STATE_Stalled;
      for (int i = 1; i <= 5; i++) begin
         tick();
         @(negedge clk);
         total++; if (s_stall_cnt !== 2'((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, s_stall_cnt, (i > 3) ? 3 : i); end
      end
      s_ctrl = `CTRL_STATE_Default;
      tick();
      @(negedge clk);
      total++; if ({s_stall_cnt, s_bubble_cnt} !== 4'b1100) begin bad++; $display("FAIL sat_hold got %0d/%0d exp 3/0", s_stall_cnt, s_bubble_cnt); end
      tick();
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      #2;
      total++; if ({out_valid, out_data} !== {1'b1, 8'h99}) begin bad++; $display("FAIL ar_pre got %b/%h exp 1/99", out_valid, out_data); end
      rst = 1'b0;
      #1;
      total++; if ({out_valid, occ, out_data} !== {1'b0, 2'd0, BV}) begin bad++; $display("FAIL ar_clear got %b/%0d/%h exp 0/0/%h", out_valid, occ, out_data, BV); end
      total++; if ({stall_cnt, bubble_cnt, s_stall_cnt} !== 34'd0) begin bad++; $display("FAIL ar_cnt got %0d/%0d/%0d exp 0", stall_cnt, bubble_cnt, s_stall_cnt); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      tick();
      test_stall();
      tick();
      test_flush();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
